fpga_rst_ctrl: RTL and testbench
================================

FPGA_RST_CTRL -- requirements
Module: fpga_rst_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flop count of each input synchronizer (min 2).
REQ-002 SHALL have parameter DB_CYCLES, default 1000: consecutive stable samples needed to accept a button level change (1..65535).
REQ-003 SHALL have parameter STRETCH_CYCLES, default 64: minimum low time of sys_rst_n_o in cycles (1..65535).
REQ-004 SHALL have port clk_i, input, 1: system clock from the clock-wizard output.
REQ-005 SHALL have port rst_n_i, input, 1: block reset; one clock, reset asynchronous active-low.
REQ-006 SHALL have port pll_locked_i, input, 1: clock-wizard lock flag, asynchronous to clk_i.
REQ-007 SHALL have port btn_rst_n_i, input, 1: raw board reset button, active-low, asynchronous and bouncing.
REQ-008 SHALL have port sw_rst_req_i, input, 1: single-cycle software reset request, synchronous to clk_i.
REQ-009 SHALL have port sys_rst_n_o, input-side consumer retrosoc_asic rst_n_i_pad, output, 1: registered, conditioned SoC reset, active-low.
REQ-010 SHALL have port rst_cause_o, output, 2: cause of the last reset (00 POR, 01 LOCK, 10 BTN, 11 SW).
REQ-011 SHALL have port rst_count_o, output, 8: number of reset events since POR, saturating at 255.

Function
REQ-012 SHALL pass pll_locked_i and btn_rst_n_i through SYNC_STAGES-flop synchronizers, each reset to 0.
REQ-013 SHALL debounce the synchronized button: change the debounced level only after DB_CYCLES consecutive cycles of the new level; any mismatch clears the counter; debounced level resets to 1 (released).
REQ-014 SHALL implement FSM states S_WAIT_LOCK, S_STRETCH, S_RUN; reset state S_WAIT_LOCK.
REQ-015 In S_WAIT_LOCK: synchronized lock=1 -> S_STRETCH with the stretch counter cleared; otherwise stay.
REQ-016 In S_STRETCH: counter increments each cycle; at STRETCH_CYCLES-1 -> S_RUN; synchronized lock=0 -> S_WAIT_LOCK; debounced button pressed -> counter cleared and state held.
REQ-017 In S_RUN, priority: lock=0 -> S_WAIT_LOCK with cause LOCK; else button pressed -> S_STRETCH with cause BTN; else sw_rst_req_i=1 -> S_STRETCH with cause SW.
REQ-018 SHALL ignore sw_rst_req_i outside S_RUN.
REQ-019 sys_rst_n_o SHALL be a flop loaded with (next_state == S_RUN), so it rises on the same edge the FSM enters S_RUN and falls on the same edge it leaves.
REQ-020 SHALL update rst_cause_o and increment rst_count_o only on an S_RUN exit; 255 SHALL hold at 255.
REQ-021 With pll_locked_i held high and no other events, sys_rst_n_o SHALL rise exactly SYNC_STAGES+1+STRETCH_CYCLES edges after pll_locked_i rises before an edge.
REQ-022 Lock loss during a button hold SHALL take priority: -> S_WAIT_LOCK, cause LOCK.

Reset
REQ-023 On rst_n_i=0, asynchronously: state S_WAIT_LOCK, sys_rst_n_o=0, rst_cause_o=00, rst_count_o=0, all counters 0, synchronizers 0, debounced level 1.
REQ-024 Release of rst_n_i SHALL be usable without a glitch on sys_rst_n_o; sys_rst_n_o SHALL stay 0 until REQ-021 timing completes.

Structure
REQ-025 Shared package retrosoc_rst_pkg SHALL hold the FSM state encoding and the 2-bit cause constants.
REQ-026 Synchronizer SHALL be sub-module retrosoc_sync (parameter STAGES, async active-low reset), instantiated twice.
REQ-027 Target size 120-250 RTL lines; no latches, no combinational path from any input to any output.

Verification (SYNC_STAGES=2, DB_CYCLES=4, STRETCH_CYCLES=8)
REQ-028 POR: release rst_n_i with pll_locked_i=1 -> sys_rst_n_o rises at edge 11; cause 00; count 0.
REQ-029 Bounce: button low 3 cycles, high 1, low 3 cycles -> no reset; then low 10 cycles -> sys_rst_n_o falls; rises 8 edges after debounced release; cause 10; count 1.
REQ-030 Software: one-cycle sw_rst_req_i in S_RUN -> sys_rst_n_o low exactly 8 cycles; cause 11; a pulse while low is ignored (count +1 only).
REQ-031 Lock loss: pll_locked_i low in S_RUN -> sys_rst_n_o low 3 edges later, held while unlocked; relock -> high 11 edges after; cause 01.
REQ-032 Simultaneous lock loss, button press, sw request in S_RUN -> cause 01; count saturates at 255 after 300 sw requests.

Source files
------------

// File: rtl/retrosoc_rst_pkg.sv
// rtl/retrosoc_rst_pkg.sv - reset controller FSM encoding, cause codes and helpers
package retrosoc_rst_pkg;

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_STRETCH   = 2'd1,
    S_RUN       = 2'd2
  } rst_state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_BTN  = 2'b10;
  localparam logic [1:0] CAUSE_SW   = 2'b11;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/retrosoc_sync.sv
// rtl/retrosoc_sync.sv - multi-flop synchronizer for a single asynchronous bit
module retrosoc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fpga_rst_ctrl.sv
// rtl/fpga_rst_ctrl.sv - SoC reset conditioner: lock/button/software sources, stretch, cause log
module fpga_rst_ctrl
  import retrosoc_rst_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DB_CYCLES      = 1000,
  parameter int STRETCH_CYCLES = 64
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       pll_locked_i,
  input  logic       btn_rst_n_i,
  input  logic       sw_rst_req_i,
  output logic       sys_rst_n_o,
  output logic [1:0] rst_cause_o,
  output logic [7:0] rst_count_o
);

  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);
  localparam logic [15:0] ST_LAST = 16'(STRETCH_CYCLES - 1);

  logic lock_sync;
  logic btn_sync;

  retrosoc_sync #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (pll_locked_i),
    .q_o     (lock_sync)
  );

  retrosoc_sync #(.STAGES(SYNC_STAGES)) u_sync_btn (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (btn_rst_n_i),
    .q_o     (btn_sync)
  );

  logic        db_q, db_d;
  logic [15:0] db_cnt_q, db_cnt_d;
  rst_state_e  state_q, state_d;
  logic [15:0] st_cnt_q, st_cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic [7:0]  count_q, count_d;
  logic        sys_rst_n_q, sys_rst_n_d;
  logic        btn_pressed;

  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    if (btn_sync == db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_d     = btn_sync;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 16'd1;
    end
  end

  assign btn_pressed = ~db_q;

  always_comb begin
    state_d  = state_q;
    st_cnt_d = st_cnt_q;
    cause_d  = cause_q;
    count_d  = count_q;
    case (state_q)
      S_WAIT_LOCK: begin
        if (lock_sync) begin
          state_d  = S_STRETCH;
          st_cnt_d = '0;
        end
      end
      S_STRETCH: begin
        // A held button keeps restarting the stretch window
        if (!lock_sync) begin
          state_d = S_WAIT_LOCK;
        end else if (btn_pressed) begin
          st_cnt_d = '0;
        end else if (st_cnt_q == ST_LAST) begin
          state_d = S_RUN;
        end else begin
          st_cnt_d = st_cnt_q + 16'd1;
        end
      end
      S_RUN: begin
        if (!lock_sync) begin
          state_d = S_WAIT_LOCK;
          cause_d = CAUSE_LOCK;
          count_d = sat_inc8(count_q);
        end else if (btn_pressed) begin
          state_d  = S_STRETCH;
          st_cnt_d = '0;
          cause_d  = CAUSE_BTN;
          count_d  = sat_inc8(count_q);
        end else if (sw_rst_req_i) begin
          state_d  = S_STRETCH;
          st_cnt_d = '0;
          cause_d  = CAUSE_SW;
          count_d  = sat_inc8(count_q);
        end
      end
      default: state_d = S_WAIT_LOCK;
    endcase
    sys_rst_n_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      db_q        <= 1'b1;
      db_cnt_q    <= '0;
      state_q     <= S_WAIT_LOCK;
      st_cnt_q    <= '0;
      cause_q     <= CAUSE_POR;
      count_q     <= '0;
      sys_rst_n_q <= 1'b0;
    end else begin
      db_q        <= db_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      st_cnt_q    <= st_cnt_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
      sys_rst_n_q <= sys_rst_n_d;
    end
  end

  assign sys_rst_n_o = sys_rst_n_q;
  assign rst_cause_o = cause_q;
  assign rst_count_o = count_q;

endmodule

// File: tb/tb_fpga_rst_ctrl.sv
// tb/tb_fpga_rst_ctrl.sv - scoreboard bench: expected sys_rst_n_o edges queued, monitor compares
module tb_fpga_rst_ctrl;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       btn_rst_n;
  logic       sw_rst_req;
  logic       sys_rst_n;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;

  fpga_rst_ctrl #(
    .SYNC_STAGES    (2),
    .DB_CYCLES      (4),
    .STRETCH_CYCLES (8)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .pll_locked_i (pll_locked),
    .btn_rst_n_i  (btn_rst_n),
    .sw_rst_req_i (sw_rst_req),
    .sys_rst_n_o  (sys_rst_n),
    .rst_cause_o  (rst_cause),
    .rst_count_o  (rst_count)
  );

  typedef struct {
    int         cyc;
    logic       lvl;
    logic [1:0] cause;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_lvl = 1'b0;
  int   exp_count = 0;
  int   base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic l, input logic [1:0] ca, input int cn);
    exp_t e;
    e.cyc = c; e.lvl = l; e.cause = ca; e.cnt = 8'(cn);
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_val(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every change of sys_rst_n_o must match the head of the queue
  always @(negedge clk) begin
    if (sys_rst_n !== prev_lvl) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_edge: cyc=%0d lvl=%b cause=%0d count=%0d, expected no edge",
                 cyc, sys_rst_n, rst_cause, rst_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cyc != e.cyc || sys_rst_n !== e.lvl || rst_cause !== e.cause || rst_count !== e.cnt) begin
          n_errors++;
          $display("FAIL edge: got cyc=%0d lvl=%b cause=%0d count=%0d, expected cyc=%0d lvl=%b cause=%0d count=%0d",
                   cyc, sys_rst_n, rst_cause, rst_count, e.cyc, e.lvl, e.cause, e.cnt);
        end
      end
      prev_lvl = sys_rst_n;
    end
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    btn_rst_n  = 1'b1;
    sw_rst_req = 1'b0;
    step(3);
    check_val("reset_sys_rst_n", int'(sys_rst_n), 0);
    check_val("reset_cause", int'(rst_cause), 0);
    check_val("reset_count", int'(rst_count), 0);

    // POR release with lock already high
    rst_n = 1'b1;
    push(cyc + 11, 1'b1, 2'b00, 0);
    step(15);

    // Bounce: short low bursts must not trigger a reset
    btn_rst_n = 1'b0; step(3);
    btn_rst_n = 1'b1; step(1);
    btn_rst_n = 1'b0; step(3);
    btn_rst_n = 1'b1; step(10);

    // Real press of 10 cycles
    base = cyc;
    exp_count = 1;
    push(base + 7, 1'b0, 2'b10, exp_count);
    push(base + 24, 1'b1, 2'b10, exp_count);
    btn_rst_n = 1'b0; step(10);
    btn_rst_n = 1'b1; step(20);

    // Software request, plus an ignored pulse while reset is held
    base = cyc;
    exp_count = 2;
    push(base + 1, 1'b0, 2'b11, exp_count);
    push(base + 9, 1'b1, 2'b11, exp_count);
    sw_rst_req = 1'b1; step(1);
    sw_rst_req = 1'b0; step(3);
    sw_rst_req = 1'b1; step(1);
    sw_rst_req = 1'b0; step(12);

    // Lock loss, held, then relock
    base = cyc;
    exp_count = 3;
    push(base + 3, 1'b0, 2'b01, exp_count);
    pll_locked = 1'b0; step(20);
    base = cyc;
    push(base + 11, 1'b1, 2'b01, exp_count);
    pll_locked = 1'b1; step(15);

    // Lock loss, debounced press and sw request all reach the FSM on one edge
    base = cyc;
    exp_count = 4;
    push(base + 7, 1'b0, 2'b01, exp_count);
    btn_rst_n = 1'b0; step(4);
    pll_locked = 1'b0; step(2);
    sw_rst_req = 1'b1; step(1);
    sw_rst_req = 1'b0;
    btn_rst_n = 1'b1; step(13);
    base = cyc;
    push(base + 11, 1'b1, 2'b01, exp_count);
    pll_locked = 1'b1; step(15);

    // 300 software requests: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      base = cyc;
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      push(base + 1, 1'b0, 2'b11, exp_count);
      push(base + 9, 1'b1, 2'b11, exp_count);
      sw_rst_req = 1'b1; step(1);
      sw_rst_req = 1'b0; step(11);
    end
    check_val("count_saturated", int'(rst_count), 255);

    // Asynchronous reset mid-run, then a clean POR sequence
    #2;
    push(cyc, 1'b0, 2'b00, 0);
    rst_n = 1'b0;
    #1;
    check_val("async_sys_rst_n", int'(sys_rst_n), 0);
    check_val("async_cause", int'(rst_cause), 0);
    check_val("async_count", int'(rst_count), 0);
    step(2);
    rst_n = 1'b1;
    push(cyc + 11, 1'b1, 2'b00, 0);
    step(15);

    check_val("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
